// File: rtl/control_registers.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : control_registers                                             |
// | Desc   : Addressable bank of control registers, synchronous write port |
// |          and independent combinational read port.                      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module control_registers #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 2**ADDR_WIDTH,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [NUM_REGS*DATA_WIDTH-1:0] w_regs_flat;

  // Each register decodes its own write strobe; addresses beyond NUM_REGS
  // match no register, so such writes fall away naturally.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic                  w_wr_sel;
      logic [DATA_WIDTH-1:0] r_q;

      assign w_wr_sel = write_enable && (write_addr == ADDR_WIDTH'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= RESET_VALUE[gi*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_wr_sel) begin
          r_q <= write_data;
        end
      end

      assign w_regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end
  endgenerate

  // Unmatched (out-of-range) read addresses keep the zero default.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_addr == ADDR_WIDTH'(i)) begin
        read_data = w_regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_registers.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_control_registers                                          |
// | Desc   : Directed and randomized self-checking bench for the register  |
// |          bank against an array-based reference model.                  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_control_registers;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] read_addr = '0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_enable = 1'b0;
  logic [DW-1:0] read_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] model [NR];

  control_registers #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_addr   (read_addr),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_enable(write_enable),
    .read_data   (read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] a);
    if (int'(a) < NR) return model[int'(a)];
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // One clock edge: the model applies the write the edge should commit,
  // then control returns on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n && write_enable && int'(write_addr) < NR) model[int'(write_addr)] = write_data;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Reset with a coincident write that must be discarded.
    rst_n = 1'b0; write_enable = 1'b1; write_addr = 3'd4; write_data = 8'hEE;
    tick(); tick();
    rst_n = 1'b1; write_enable = 1'b0;
    tick();
    for (int a = 0; a < NR; a++) begin
      read_addr = AW'(a); #1;
      check($sformatf("reset_rd%0d", a), read_data, 8'h00);
    end

    // Back-to-back writes into register 0.
    read_addr = 3'd0; write_addr = 3'd0; write_enable = 1'b1;
    for (int v = 0; v < 8; v++) begin
      write_data = DW'(v); #1;
      check($sformatf("b2b_pre%0d", v), read_data, expect_read(read_addr));
      tick();
      check($sformatf("b2b_post%0d", v), read_data, DW'(v));
    end

    // Second register, then confirm register 0 untouched.
    write_addr = 3'd1; write_data = 8'h00; tick();
    write_data = 8'h01; tick();
    write_enable = 1'b0;
    read_addr = 3'd1; #1; check("reg1_rd", read_data, 8'h01);
    read_addr = 3'd0; #1; check("reg0_hold", read_data, 8'h07);

    // Disabled writes.
    write_addr = 3'd0; write_data = 8'hAA;
    tick(); tick(); tick();
    check("wr_disabled", read_data, 8'h07);

    // Same-address read/write: old value before the edge, new after.
    read_addr = 3'd2; write_addr = 3'd2; write_data = 8'h5C; write_enable = 1'b1; #1;
    check("same_addr_old", read_data, 8'h00);
    tick();
    check("same_addr_new", read_data, 8'h5C);

    // Async reset between edges with writes active.
    write_addr = 3'd3; write_data = 8'h33;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_rst_imm", read_data, 8'h00);
    tick();
    read_addr = 3'd3; #1; check("async_rst_nowr", read_data, 8'h00);
    rst_n = 1'b1;
    tick();
    check("wr_after_rel", read_data, 8'h33);

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 300; n++) begin
      write_enable = ($urandom_range(0, 3) != 0);
      write_addr   = AW'($urandom_range(0, NR - 1));
      write_data   = DW'($urandom);
      read_addr    = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom_range(0, NR - 1));
      #1 check("rnd_pre", read_data, expect_read(read_addr));
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("rnd_async_rst", read_data, 8'h00);
        tick();
        rst_n = 1'b1;
        #1;
      end else begin
        tick();
        check("rnd_post", read_data, expect_read(read_addr));
      end
    end

    // Full sweep of final contents.
    write_enable = 1'b0;
    for (int a = 0; a < NR; a++) begin
      read_addr = AW'(a); #1;
      check($sformatf("final_rd%0d", a), read_data, expect_read(read_addr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
